// File: rtl/spi_sample_scheduler.sv
// rtl/spi_sample_scheduler.sv - periodic burst sequencer for the SPI ADC master; optional per-channel filter under SPI_SCHED_AVG_EN
module spi_sample_scheduler #(
  parameter int NUM_CH  = 4,
  parameter int CH_W    = 2,
  parameter int DATA_W  = 12,
  parameter int PERIOD  = 10000,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              spi_busy,
  input  logic              spi_data_valid,
  input  logic [DATA_W-1:0] spi_data,
  output logic              spi_start,
  output logic [CH_W-1:0]   spi_ch,
  output logic              sample_valid,
  output logic [CH_W-1:0]   sample_ch,
  output logic [DATA_W-1:0] sample_data,
  output logic              burst_done,
  output logic              timeout_err,
  output logic              overrun
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  // One extra bit so idx can point one past the last channel without wrapping.
  localparam int IDX_W = CH_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_START,
    S_WAIT_DONE,
    S_SETTLE
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              tick;
  logic [NUM_CH-1:0] mask_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  next_idx;
  logic [TMO_W-1:0]  tmo_q;
  logic [SET_W-1:0]  set_q;
  logic              spi_start_q;
  logic [CH_W-1:0]   spi_ch_q;
  logic              sample_valid_q;
  logic [CH_W-1:0]   sample_ch_q;
  logic [DATA_W-1:0] sample_data_q;
  logic              timeout_err_q;
  logic              overrun_q;
  logic              found;
  logic [CH_W-1:0]   found_ch;
  logic [DATA_W-1:0] result_d;

  assign tick     = enable && (cnt_q == CNT_W'(PERIOD - 1));
  assign next_idx = {1'b0, spi_ch_q} + 1'b1;

  // Period timer next value: counts while enabled, wraps on tick, parks at 0 when disabled
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!enable || tick) begin
      cnt_d = '0;
    end
  end

  // Period timer register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Lowest enabled channel at or above the resume index
  always_comb begin
    found    = 1'b0;
    found_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i] && (IDX_W'(i) >= idx_q)) begin
        found    = 1'b1;
        found_ch = CH_W'(i);
      end
    end
  end

`ifdef SPI_SCHED_AVG_EN
  logic [DATA_W+1:0]        avg_q [NUM_CH];
  logic [NUM_CH-1:0]        seen_q;
  logic signed [DATA_W+2:0] new_s;
  logic signed [DATA_W+2:0] avg_s;
  logic signed [DATA_W+2:0] sum_s;

  // Filter update: avg += (new - avg) / 4 (arithmetic), first sample seeds the state
  always_comb begin
    new_s    = $signed({3'b000, spi_data});
    avg_s    = $signed({avg_q[spi_ch_q][DATA_W+1], avg_q[spi_ch_q]});
    sum_s    = avg_s + ((new_s - avg_s) >>> 2);
    result_d = seen_q[spi_ch_q] ? sum_s[DATA_W-1:0] : spi_data;
  end

  // Per-channel filter state, written only when a result is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      seen_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        avg_q[i] <= '0;
      end
    end else if (state_q == S_WAIT_DONE && spi_data_valid) begin
      seen_q[spi_ch_q] <= 1'b1;
      avg_q[spi_ch_q]  <= seen_q[spi_ch_q] ? sum_s[DATA_W+1:0] : {2'b00, spi_data};
    end
  end
`else
  assign result_d = spi_data;
`endif

  // Burst sequencer with registered strobes and sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      mask_q         <= '0;
      idx_q          <= '0;
      tmo_q          <= '0;
      set_q          <= '0;
      spi_start_q    <= 1'b0;
      spi_ch_q       <= '0;
      sample_valid_q <= 1'b0;
      sample_ch_q    <= '0;
      sample_data_q  <= '0;
      timeout_err_q  <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      spi_start_q    <= 1'b0;
      sample_valid_q <= 1'b0;
      // Any tick not consumed in IDLE is lost, including the cycle we fall back to IDLE.
      if (tick && state_q != S_IDLE) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (tick) begin
            mask_q  <= ch_mask;
            idx_q   <= '0;
            state_q <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (found) begin
            spi_ch_q <= found_ch;
            state_q  <= S_START;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_START: begin
          if (!spi_busy) begin
            spi_start_q <= 1'b1;
            tmo_q       <= '0;
            state_q     <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          // A result arriving on the timeout cycle still counts as success.
          if (spi_data_valid) begin
            sample_ch_q    <= spi_ch_q;
            sample_data_q  <= result_d;
            sample_valid_q <= 1'b1;
            idx_q          <= next_idx;
            set_q          <= '0;
            state_q        <= S_SETTLE;
          end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            timeout_err_q <= 1'b1;
            idx_q         <= next_idx;
            set_q         <= '0;
            state_q       <= S_SETTLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_SETTLE: begin
          if (set_q == SET_W'(SETTLE - 1)) begin
            state_q <= enable ? S_SELECT : S_IDLE;
          end else begin
            set_q <= set_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // End of burst is decoded in SELECT so an empty mask finishes one cycle after the tick.
  assign burst_done   = (state_q == S_SELECT) && !found;
  assign spi_start    = spi_start_q;
  assign spi_ch       = spi_ch_q;
  assign sample_valid = sample_valid_q;
  assign sample_ch    = sample_ch_q;
  assign sample_data  = sample_data_q;
  assign timeout_err  = timeout_err_q;
  assign overrun      = overrun_q;

endmodule
